serial_word_loader: RTL and testbench

//  Upstream feeder for the 4-bit parallel-load register stage.
//  - Receives a framed serial bit stream: start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
//  - Assembles each frame into a WIDTH-bit word.
//  - Drives word/load straight into the register's I/load inputs, issuing exactly one load pulse per good frame.
//  - Bad frames raise an error pulse and a saturating error count.

---
 rtl/serial_word_loader_pkg.sv | 29 ++
 rtl/serial_word_loader_sipo_shift.sv | 43 ++++
 rtl/serial_word_loader.sv | 157 +++++++++++++++
 tb/tb_serial_word_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader: FSM state encodings,
// error counter width and a saturating-increment helper.
package serial_pkg;

    // Two-bit state encodings, also visible on the debug state output.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;

    // Width of the bad-frame counter.
    localparam int ERR_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (v == {ERR_CNT_W{1'b1}}) begin
            return v;
        end
        return v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/serial_word_loader_sipo_shift.sv
// Serial-in / parallel-out shift register. New bits enter at the MSB and
// move toward the LSB, so an LSB-first stream lands in natural bit order
// after WIDTH shifts.
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Next value: synchronous clear wins over shifting; otherwise hold.
    always_comb begin
        shift_d = shift_q;
        if (clr) begin
            shift_d = '0;
        end else if (en) begin
            if (WIDTH > 1) begin
                shift_d = {din, shift_q[WIDTH-1:1]};
            end else begin
                shift_d[WIDTH-1] = din;
            end
        end
    end

    // Shift register storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/serial_word_loader.sv
// Framed serial receiver feeding a parallel-load register stage.
// Frame: start(0), WIDTH data bits LSB first, optional parity, stop(1).
// A good frame updates word and pulses load once; a bad frame pulses
// frame_err or parity_err and bumps a saturating error count.
//
// Handshake: load is a one-cycle valid strobe with no ready; word is valid
// in the cycle load is high and holds its value until the next good frame.
module serial_word_loader
    import serial_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1,
    parameter bit ODD_PAR   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 sin,
    output logic [WIDTH-1:0]     word,
    output logic                 load,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q,      state_d;
    logic [CNT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic                 par_acc_q,    par_acc_d;
    logic                 par_bit_q,    par_bit_d;
    logic [WIDTH-1:0]     word_q,       word_d;
    logic                 load_q,       load_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

    logic             shift_en;
    logic             shift_clr;
    logic [WIDTH-1:0] shift_word;
    logic             par_ok;

    sipo_shift #(
        .WIDTH(WIDTH)
    ) u_sipo (
        .clk (clk),
        .rst (rst),
        .clr (shift_clr),
        .en  (shift_en),
        .din (sin),
        .q   (shift_word)
    );

    // Parity check: XOR of data bits and parity bit must equal ODD_PAR.
    always_comb begin
        par_ok = 1'b1;
        if (PARITY_EN) begin
            par_ok = ((par_acc_q ^ par_bit_q) == ODD_PAR);
        end
    end

    // Next-state and output logic; pulses default low every cycle so they
    // clear on the next edge whether or not a bit strobe is present.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        par_acc_d    = par_acc_q;
        par_bit_d    = par_bit_q;
        word_d       = word_q;
        load_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        err_cnt_d    = err_cnt_q;
        shift_en     = 1'b0;
        shift_clr    = 1'b0;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!sin) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        par_acc_d = 1'b0;
                        par_bit_d = 1'b0;
                        shift_clr = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_en  = 1'b1;
                    par_acc_d = par_acc_q ^ sin;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    par_bit_d = sin;
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (sin && par_ok) begin
                        word_d = shift_word;
                        load_d = 1'b1;
                    end else begin
                        // A bad stop bit masks any parity problem.
                        if (!sin) begin
                            frame_err_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            par_acc_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            word_q       <= '0;
            load_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            par_acc_q    <= par_acc_d;
            par_bit_q    <= par_bit_d;
            word_q       <= word_d;
            load_q       <= load_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign word       = word_q;
    assign load       = load_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign err_cnt    = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader (WIDTH=4, even parity, one bit
// strobe every four clocks).
module tb_serial_word_loader;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       sin;
    logic [3:0] word;
    logic       load;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    int load_seen = 0;
    int ferr_seen = 0;
    int perr_seen = 0;
    logic load_after_strobe = 1'b0;

    logic [3:0] exp_q[$];

    serial_word_loader #(
        .WIDTH(4),
        .PARITY_EN(1'b1),
        .ODD_PAR(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sin        (sin),
        .word       (word),
        .load       (load),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .err_cnt    (err_cnt),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every load must match the next expected word; pulses are
    // counted once per cycle high so a stretched pulse shows up in the totals.
    always @(negedge clk) begin
        if (!rst) begin
            if (load) begin
                load_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_load", 32'd1, 32'd0);
                end else begin
                    check_eq("load_word", {28'd0, word}, {28'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) ferr_seen++;
            if (parity_err) perr_seen++;
            if (frame_err || parity_err) begin
                check_eq("err_exclusive", {31'd0, frame_err & parity_err}, 32'd0);
            end
        end
    end

    // Driver: one bit per four clocks, strobe high for a single clock.
    task automatic send_bit(input logic b);
        @(negedge clk);
        sin    = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        load_after_strobe = load;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] data, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    int l0, f0, p0;

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        sin    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_word", {28'd0, word}, 32'd0);
        check_eq("rst_load", {31'd0, load}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_errs", {30'd0, frame_err, parity_err}, 32'd0);
        check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Good frame 0xA, even parity 0
        exp_q.push_back(4'hA);
        send_frame(4'hA, 1'b0, 1'b1);
        check_eq("t1_load_on_stop", {31'd0, load_after_strobe}, 32'd1);
        check_eq("t1_load_count", load_seen, 32'd1);
        check_eq("t1_word", {28'd0, word}, 32'hA);
        check_eq("t1_load_low", {31'd0, load}, 32'd0);
        check_eq("t1_errs", ferr_seen + perr_seen, 32'd0);
        check_eq("t1_err_cnt", {24'd0, err_cnt}, 32'd0);

        // 2. Data 0xF with parity 1 (bad for even), stop good
        send_frame(4'hF, 1'b1, 1'b1);
        check_eq("t2_perr", perr_seen, 32'd1);
        check_eq("t2_ferr", ferr_seen, 32'd0);
        check_eq("t2_err_cnt", {24'd0, err_cnt}, 32'd1);
        check_eq("t2_no_load", load_seen, 32'd1);
        check_eq("t2_word_held", {28'd0, word}, 32'hA);

        // 3. Data 0x1, parity 1 (good) but stop 0: frame error only
        send_frame(4'h1, 1'b1, 1'b0);
        check_eq("t3_ferr", ferr_seen, 32'd1);
        check_eq("t3_perr", perr_seen, 32'd1);
        check_eq("t3_err_cnt", {24'd0, err_cnt}, 32'd2);
        check_eq("t3_idle", {30'd0, dbg_state}, 32'd0);
        check_eq("t3_not_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(4'h3);
        send_frame(4'h3, 1'b0, 1'b1);
        check_eq("t3_word", {28'd0, word}, 32'h3);
        check_eq("t3_load_count", load_seen, 32'd2);

        // 4. Reset after two data bits of 0x5
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("t4_busy_mid", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t4_rst_state", {30'd0, dbg_state}, 32'd0);
        check_eq("t4_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t4_rst_word", {28'd0, word}, 32'd0);
        check_eq("t4_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        l0 = load_seen;
        exp_q.push_back(4'h6);
        send_frame(4'h6, 1'b0, 1'b1);
        check_eq("t4_word", {28'd0, word}, 32'h6);
        check_eq("t4_single_load", load_seen - l0, 32'd1);

        // 5. Back-to-back 0x1 then 0xE with a 10-clock strobe stall
        l0 = load_seen;
        exp_q.push_back(4'h1);
        send_frame(4'h1, 1'b1, 1'b1);
        check_eq("t5_word1", {28'd0, word}, 32'h1);
        exp_q.push_back(4'hE);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        check_eq("t5_stall_state", {30'd0, dbg_state}, 32'd1);
        check_eq("t5_stall_word", {28'd0, word}, 32'h1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("t5_word2", {28'd0, word}, 32'hE);
        check_eq("t5_loads", load_seen - l0, 32'd2);

        // 6. Stop-error frames drive err_cnt into saturation
        f0 = ferr_seen;
        p0 = perr_seen;
        for (int i = 0; i < 254; i++) send_frame(4'h0, 1'b0, 1'b0);
        check_eq("t6_cnt_254", {24'd0, err_cnt}, 32'hFE);
        send_frame(4'h0, 1'b0, 1'b0);
        check_eq("t6_cnt_255", {24'd0, err_cnt}, 32'hFF);
        for (int i = 0; i < 5; i++) send_frame(4'h0, 1'b0, 1'b0);
        check_eq("t6_cnt_260", {24'd0, err_cnt}, 32'hFF);
        send_frame(4'h0, 1'b0, 1'b0);
        check_eq("t6_cnt_261", {24'd0, err_cnt}, 32'hFF);
        check_eq("t6_ferr_pulses", ferr_seen - f0, 32'd261);
        check_eq("t6_perr_pulses", perr_seen - p0, 32'd0);
        check_eq("t6_word_held", {28'd0, word}, 32'hE);

        // Final report
        check_eq("total_loads", load_seen, 32'd5);
        check_eq("exp_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
